// File: rtl/rand_beat_server.sv
// rand_beat_server
//   CPU-side output server for the TRNG. Pops one MAX_BITS-wide word from
//   the selected entropy channel and serves it as OUT_W-bit beats, one beat
//   per slow_tick. The request size decides the beat count. Any bits of the
//   word above the request size are zeroed, so a short final beat comes out
//   zero-padded.
//
//   Optional feature: define RAND_BEAT_PROTOCOL_CHECK_EN to build the sticky
//   protocol checker behind proto_err. Without it, proto_err is tied to 0.
//
// Ports
//   ic_clk         block clock
//   rst            asynchronous, active-high reset
//   slow_tick      1-cycle pacing strobe, already synchronised
//   rand_req       request level; hold it high for back-to-back requests
//   rand_req_size  0:16b 1:32b 2:64b 3:128b (clamped to MAX_BITS)
//   rand_req_src   source channel; out-of-range values map to channel 0
//   src_word       per-channel words, channel i at [i*MAX_BITS +: MAX_BITS]
//   src_valid      per-channel word valid
//   src_ready      per-channel pop, one-hot or zero
//   rand_out       current beat; it holds the last beat between strobes
//   rand_valid     1-cycle beat strobe
//   rand_last      marks the final beat of a request
//   busy           high while the server is away from IDLE
//   proto_err      sticky protocol error
//
// state | meaning
// IDLE  | waiting for rand_req; latches size/src on accept
// FETCH | src_ready asserted on the selected channel until a word is popped
// SERVE | one beat per slow_tick until the beat count is reached
module rand_beat_server #(
    parameter int OUT_W    = 16,
    parameter int MAX_BITS = 64,
    parameter int NUM_SRC  = 2,
    localparam int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                        ic_clk,
    input  logic                        rst,
    input  logic                        slow_tick,
    input  logic                        rand_req,
    input  logic [1:0]                  rand_req_size,
    input  logic [SW-1:0]               rand_req_src,
    input  logic [NUM_SRC*MAX_BITS-1:0] src_word,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic [OUT_W-1:0]            rand_out,
    output logic                        rand_valid,
    output logic                        rand_last,
    output logic                        busy,
    output logic                        proto_err
);

    localparam int CW = $clog2(MAX_BITS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, SERVE} state_t;

    function automatic int req_bits(input logic [1:0] sz);
        int b;
        b = 16 << int'(sz);
        if (b > MAX_BITS) b = MAX_BITS;
        return b;
    endfunction

    function automatic logic [CW-1:0] req_beats(input logic [1:0] sz);
        return CW'((req_bits(sz) + OUT_W - 1) / OUT_W);
    endfunction

    function automatic logic [MAX_BITS-1:0] req_mask(input logic [1:0] sz);
        logic [MAX_BITS-1:0] m;
        int b;
        b = req_bits(sz);
        for (int i = 0; i < MAX_BITS; i++) m[i] = (i < b);
        return m;
    endfunction

    state_t              state, state_nx;
    logic [1:0]          size_q;
    logic [SW-1:0]       src_q;
    logic [CW-1:0]       beats_q;
    logic [CW-1:0]       cnt_q;
    logic [MAX_BITS-1:0] shreg;
    logic [OUT_W-1:0]    hold_q;

    logic [SW-1:0]       src_eff;
    logic [MAX_BITS-1:0] sel_word;
    logic                sel_valid;
    logic                fetch_go;
    logic                capture;
    logic                beat;
    logic                final_beat;

    assign src_eff   = (int'(src_q) >= NUM_SRC) ? '0 : src_q;
    assign sel_word  = src_word[int'(src_eff)*MAX_BITS +: MAX_BITS];
    assign sel_valid = src_valid[src_eff];

    // Dropping rand_req withdraws src_ready in the same cycle, so an aborted
    // fetch never pops a word.
    assign fetch_go   = (state == FETCH) && rand_req;
    assign capture    = fetch_go && sel_valid;
    assign beat       = (state == SERVE) && rand_req && slow_tick;
    assign final_beat = beat && ((cnt_q + CW'(1)) == beats_q);

    always_comb begin
        state_nx  = state;
        src_ready = '0;
        if (fetch_go) src_ready[src_eff] = 1'b1;
        case (state)
            IDLE:    if (rand_req) state_nx = FETCH;
            FETCH:   if (!rand_req) state_nx = IDLE;
                     else if (capture) state_nx = SERVE;
            SERVE:   if (!rand_req || final_beat) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign rand_valid = beat;
    assign rand_last  = final_beat;
    assign rand_out   = beat ? shreg[OUT_W-1:0] : hold_q;
    assign busy       = (state != IDLE);

    always_ff @(posedge ic_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            size_q  <= '0;
            src_q   <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            shreg   <= '0;
            hold_q  <= '0;
        end else begin
            state <= state_nx;
            if ((state == IDLE) && rand_req) begin
                size_q  <= rand_req_size;
                src_q   <= rand_req_src;
                beats_q <= req_beats(rand_req_size);
                cnt_q   <= '0;
            end
            if (capture) shreg <= sel_word & req_mask(size_q);
            if (beat) begin
                shreg  <= shreg >> OUT_W;
                cnt_q  <= cnt_q + CW'(1);
                hold_q <= shreg[OUT_W-1:0];
            end
        end
    end

`ifdef RAND_BEAT_PROTOCOL_CHECK_EN
    logic err_q;
    logic req_changed;
    logic over_count;
    logic multi_ready;

    assign req_changed = (state != IDLE) &&
                         ((rand_req_size != size_q) || (rand_req_src != src_q));
    assign over_count  = (state == SERVE) && (cnt_q >= beats_q);
    assign multi_ready = ((src_ready & (src_ready - 1'b1)) != '0);

    always_ff @(posedge ic_clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if (req_changed || over_count || multi_ready) err_q <= 1'b1;
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_rand_beat_server.sv
// Testbench for rand_beat_server. Two instances share the same stimulus:
// one with OUT_W=16 and one with OUT_W=24, both MAX_BITS=64 and NUM_SRC=2.
// The driver pushes the expected beats into one queue per instance. A
// negedge monitor pops from the queue and compares on every rand_valid.
module tb_rand_beat_server;

    logic         ic_clk = 1'b0;
    logic         rst;
    logic         slow_tick;
    logic         rand_req;
    logic [1:0]   rand_req_size;
    logic         rand_req_src;
    logic [127:0] src_word;
    logic [1:0]   src_valid;

    logic [1:0]   a_src_ready, b_src_ready;
    logic [15:0]  a_rand_out;
    logic [23:0]  b_rand_out;
    logic         a_valid, a_last, a_busy, a_err;
    logic         b_valid, b_last, b_busy, b_err;

    rand_beat_server #(.OUT_W(16), .MAX_BITS(64), .NUM_SRC(2)) u_dut (
        .ic_clk(ic_clk), .rst(rst), .slow_tick(slow_tick), .rand_req(rand_req),
        .rand_req_size(rand_req_size), .rand_req_src(rand_req_src),
        .src_word(src_word), .src_valid(src_valid), .src_ready(a_src_ready),
        .rand_out(a_rand_out), .rand_valid(a_valid), .rand_last(a_last),
        .busy(a_busy), .proto_err(a_err)
    );

    rand_beat_server #(.OUT_W(24), .MAX_BITS(64), .NUM_SRC(2)) u_dut24 (
        .ic_clk(ic_clk), .rst(rst), .slow_tick(slow_tick), .rand_req(rand_req),
        .rand_req_size(rand_req_size), .rand_req_src(rand_req_src),
        .src_word(src_word), .src_valid(src_valid), .src_ready(b_src_ready),
        .rand_out(b_rand_out), .rand_valid(b_valid), .rand_last(b_last),
        .busy(b_busy), .proto_err(b_err)
    );

    always #5 ic_clk = ~ic_clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];

`ifdef RAND_BEAT_PROTOCOL_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the request covers min(16<<size, 64) bits of the word,
    // and that span is cut into ow-bit slices starting from the LSB.
    function automatic int req_bits(input int size);
        int b;
        b = 16 << size;
        return (b > 64) ? 64 : b;
    endfunction

    function automatic int nbeats(input int size, input int ow);
        return (req_bits(size) + ow - 1) / ow;
    endfunction

    function automatic logic [31:0] beat_val(input logic [63:0] w, input int size,
                                             input int ow, input int k);
        int          bits;
        logic [63:0] m;
        logic [63:0] s;
        bits = req_bits(size);
        m    = (bits >= 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
        s    = (w & m) >> (k * ow);
        return 32'(s & ((64'd1 << ow) - 64'd1));
    endfunction

    always @(negedge ic_clk) begin : monitor
        beat_t e;
        if (a_valid) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_beat: got %0h expected no strobe", a_rand_out);
            end else begin
                e = qa.pop_front();
                check("a_beat_data", 64'(a_rand_out), 64'(e.data));
                check("a_beat_last", 64'(a_last), 64'(e.last));
            end
        end
        if (b_valid) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_beat: got %0h expected no strobe", b_rand_out);
            end else begin
                e = qb.pop_front();
                check("b_beat_data", 64'(b_rand_out), 64'(e.data));
                check("b_beat_last", 64'(b_last), 64'(e.last));
            end
        end
    end

    task automatic step();
        @(posedge ic_clk);
        #1;
    endtask

    // One request. nticks ticks go out after the capture. hold keeps rand_req
    // high at the end. abort_tick adds a tick in the same cycle that rand_req
    // drops. cap_tick puts a tick in the capture cycle, where it must be
    // ignored. change_size >= 0 alters rand_req_size while the word is served.
    task automatic do_req(input int size, input int src, input logic [63:0] word,
                          input int nticks, input bit hold, input bit abort_tick,
                          input bit cap_tick, input int change_size);
        int wait_n;
        int na, nb;
        rand_req_size = 2'(size);
        rand_req_src  = 1'(src);
        rand_req      = 1'b1;
        src_word      = {$urandom, $urandom, $urandom, $urandom};
        src_word[src*64 +: 64] = word;
        wait_n = 0;
        while (!(a_src_ready[src] && b_src_ready[src]) && wait_n < 20) begin
            step();
            wait_n++;
        end
        if (!(a_src_ready[src] && b_src_ready[src])) begin
            checks++; failures++;
            $display("FAIL fetch_timeout: src_ready a=%0b b=%0b required both set", a_src_ready, b_src_ready);
            rand_req = 1'b0;
            step(); step();
            return;
        end
        src_valid      = 2'b00;
        src_valid[src] = 1'b1;
        src_valid[1-src] = 1'($urandom_range(0, 1));
        slow_tick      = cap_tick;
        step();
        src_valid = 2'b00;
        slow_tick = 1'b0;
        na = (nticks < nbeats(size, 16)) ? nticks : nbeats(size, 16);
        nb = (nticks < nbeats(size, 24)) ? nticks : nbeats(size, 24);
        for (int k = 0; k < na; k++)
            qa.push_back('{beat_val(word, size, 16, k), (k == nbeats(size, 16) - 1)});
        for (int k = 0; k < nb; k++)
            qb.push_back('{beat_val(word, size, 24, k), (k == nbeats(size, 24) - 1)});
        if (change_size >= 0) rand_req_size = 2'(change_size);
        for (int k = 0; k < nticks; k++) begin
            repeat ($urandom_range(0, 2)) step();
            slow_tick = 1'b1;
            step();
            slow_tick = 1'b0;
        end
        if (!hold) begin
            rand_req  = 1'b0;
            slow_tick = abort_tick;
            step();
            slow_tick = 1'b0;
            check("a_busy_after_drop", 64'(a_busy), 64'd0);
            check("a_ready_after_drop", 64'(a_src_ready), 64'd0);
            check("b_busy_after_drop", 64'(b_busy), 64'd0);
            step(); step();
            check("a_queue_drained", 64'(qa.size()), 64'd0);
            check("b_queue_drained", 64'(qb.size()), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        int sz, sr, nb16, nt;
        bit ab;
        rst = 1'b1; slow_tick = 1'b0; rand_req = 1'b0;
        rand_req_size = 2'd0; rand_req_src = 1'b0;
        src_word = '0; src_valid = 2'b00;
        repeat (2) step();
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_last", 64'(a_last), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_ready", 64'(a_src_ready), 64'd0);
        check("rst_out", 64'(a_rand_out), 64'd0);
        check("rst_err", 64'(a_err), 64'd0);
        rst = 1'b0;
        step();

        // Single 16-bit beat; the 24-bit instance must zero-pad above bit 15.
        do_req(0, 0, 64'h1111_2222_3333_BEEF, 1, 0, 1, 1, -1);
        // A 128-bit request is clamped to the 64-bit word.
        do_req(3, 1, 64'h0123_4567_89AB_CDEF, 4, 0, 0, 0, -1);

        // Back-to-back: with rand_req held, src_ready returns after one IDLE cycle.
        do_req(2, 1, 64'h0123_4567_89AB_CDEF, 4, 1, 0, 0, -1);
        check("b2b_idle_busy", 64'(a_busy), 64'd0);
        check("b2b_idle_ready", 64'(a_src_ready), 64'd0);
        step();
        check("b2b_ready_again", 64'(a_src_ready[1]), 64'd1);
        do_req(2, 1, 64'hFEDC_BA98_7654_3210, 4, 0, 0, 0, -1);

        // Abort after 2 beats, with a tick in the same cycle that rand_req drops.
        do_req(2, 0, 64'hA5A5_5A5A_C3C3_3C3C, 2, 0, 1, 0, -1);

        for (int i = 0; i < 30; i++) begin
            sz   = $urandom_range(0, 3);
            sr   = $urandom_range(0, 1);
            nb16 = nbeats(sz, 16);
            ab   = ($urandom_range(0, 3) == 0);
            nt   = ab ? $urandom_range(0, nb16 - 1) : nb16;
            do_req(sz, sr, {$urandom, $urandom}, nt, 0, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), -1);
        end

        // Reset in SERVE, one cycle after a beat went out.
        do_req(2, 0, 64'h0123_4567_89AB_CDEF, 1, 1, 0, 0, -1);
        slow_tick = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(a_valid), 64'd0);
        check("midrst_busy", 64'(a_busy), 64'd0);
        check("midrst_ready", 64'(a_src_ready), 64'd0);
        check("midrst_out", 64'(a_rand_out), 64'd0);
        check("midrst_out24", 64'(b_rand_out), 64'd0);
        step();
        slow_tick = 1'b0; rand_req = 1'b0; rst = 1'b0;
        step(); step();
        check("midrst_no_beats", 64'(qa.size() + qb.size()), 64'd0);

        // Size changes while the word is served: all 4 beats still go out.
        do_req(2, 0, 64'h1357_9BDF_2468_ACE0, 4, 0, 0, 0, 0);
        check("proto_err_a", 64'(a_err), 64'(ERR_EXP));
        check("proto_err_b", 64'(b_err), 64'(ERR_EXP));
        repeat (3) step();
        check("proto_err_held", 64'(a_err), 64'(ERR_EXP));
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("proto_err_cleared", 64'(a_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
